// File: rtl/acc_drain_if.sv
// Capture/drain bundle between the upstream accumulator array, acc_drain and
// the downstream byte sink.
interface acc_drain_if #(
  parameter int SIZE = 6
);
  logic [8*SIZE-1:0] acc_in;
  logic              capture;
  logic              capture_ready;
  logic              acc_clear;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;

  modport slave (
    input  acc_in, capture, m_ready,
    output capture_ready, acc_clear, m_data, m_valid, m_last, busy
  );

  modport master (
    output acc_in, capture, m_ready,
    input  capture_ready, acc_clear, m_data, m_valid, m_last, busy
  );
endinterface

// File: rtl/acc_drain.sv
// Snapshots a SIZE-lane accumulator vector and serialises it one byte per
// handshake, optionally clamping negative lanes to zero.
module acc_drain #(
  parameter int SIZE = 6,
  parameter int RELU = 0
) (
  input  logic        clk,
  input  logic        reset,
  acc_drain_if.slave  bus
);
  localparam int            IW       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_nxt_s;
  logic [7:0]    lanes_r [SIZE];
  logic          accept_s;
  logic [7:0]    lane_sel_s;
  logic [7:0]    data_nxt_s;
  logic          last_nxt_s;

  logic          capture_ready_r;
  logic          acc_clear_r;
  logic          m_valid_r;
  logic          m_last_r;
  logic          busy_r;
  logic [7:0]    m_data_r;

  function automatic logic [7:0] relu_f(input logic [7:0] v);
    logic [7:0] r;
    if ((RELU != 0) && v[7]) begin
      r = 8'h00;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // FSM state and lane index register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      idx_r   <= {IW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next-state, capture acceptance and index advance
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.capture) begin
          accept_s    = 1'b1;
          state_nxt_s = SEND;
          idx_nxt_s   = {IW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (bus.m_ready) begin
          if (idx_r == LAST_IDX) begin
            state_nxt_s = IDLE;
            idx_nxt_s   = {IW{1'b0}};
          end else begin
            idx_nxt_s = idx_r + IW'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = {IW{1'b0}};
      end
    endcase
  end

  // Value presented next cycle; on a fresh capture lane 0 comes straight from acc_in
  always_comb begin
    if (accept_s) begin
      lane_sel_s = bus.acc_in[7:0];
    end else begin
      lane_sel_s = lanes_r[idx_nxt_s];
    end
    if (state_nxt_s == SEND) begin
      data_nxt_s = relu_f(lane_sel_s);
      last_nxt_s = (idx_nxt_s == LAST_IDX);
    end else begin
      data_nxt_s = 8'h00;
      last_nxt_s = 1'b0;
    end
  end

  // Snapshot storage, written only on an accepted capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) begin
        lanes_r[i] <= 8'h00;
      end
    end else if (accept_s) begin
      for (int i = 0; i < SIZE; i++) begin
        lanes_r[i] <= bus.acc_in[8*i +: 8];
      end
    end
  end

  // Registered outputs derived from the next state, index and stored lanes
  always_ff @(posedge clk) begin
    if (!reset) begin
      capture_ready_r <= 1'b1;
      acc_clear_r     <= 1'b0;
      m_valid_r       <= 1'b0;
      m_last_r        <= 1'b0;
      busy_r          <= 1'b0;
      m_data_r        <= 8'h00;
    end else begin
      capture_ready_r <= (state_nxt_s == IDLE);
      acc_clear_r     <= accept_s;
      m_valid_r       <= (state_nxt_s == SEND);
      m_last_r        <= last_nxt_s;
      busy_r          <= (state_nxt_s == SEND);
      m_data_r        <= data_nxt_s;
    end
  end

  assign bus.capture_ready = capture_ready_r;
  assign bus.acc_clear     = acc_clear_r;
  assign bus.m_valid       = m_valid_r;
  assign bus.m_last        = m_last_r;
  assign bus.busy          = busy_r;
  assign bus.m_data        = m_data_r;

endmodule

// File: tb/tb_acc_drain.sv
// Scoreboard bench for acc_drain: one RELU=0 and one RELU=1 instance sharing
// clock and reset; expected beats are queued at capture and popped on handshake.
module tb_acc_drain;
  localparam int SIZE = 6;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  acc_drain_if #(.SIZE(SIZE)) bus0 ();
  acc_drain_if #(.SIZE(SIZE)) bus1 ();

  acc_drain #(.SIZE(SIZE), .RELU(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  acc_drain #(.SIZE(SIZE), .RELU(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;
  int clr0  = 0;
  int clr1  = 0;
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];

  localparam logic [47:0] V1     = 48'h80_7F_FE_03_02_01;
  localparam logic [47:0] V2     = 48'h60_50_40_30_20_10;
  localparam logic [47:0] VR     = 48'hFF_00_7F_80_FB_05;
  localparam logic [47:0] VR_EXP = 48'h00_00_7F_00_00_05;
  localparam logic [47:0] VAA    = 48'hAA_AA_AA_AA_AA_AA;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // acc_clear pulses, sampled before the edge updates them
  always @(posedge clk) begin
    if (bus0.acc_clear) clr0++;
    if (bus1.acc_clear) clr1++;
  end

  // Scoreboard for instance 0
  always @(negedge clk) begin : mon0
    logic [8:0] e;
    if (reset && bus0.m_valid && bus0.m_ready) begin
      check_val("d0_beat_pending", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_val("d0_data", 32'(bus0.m_data), 32'(e[7:0]));
        check_val("d0_last", 32'(bus0.m_last), 32'(e[8]));
      end
    end else if (reset && !bus0.m_valid) begin
      check_val("d0_last_idle", 32'(bus0.m_last), 32'd0);
    end
  end

  // Scoreboard for instance 1
  always @(negedge clk) begin : mon1
    logic [8:0] e;
    if (reset && bus1.m_valid && bus1.m_ready) begin
      check_val("d1_beat_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_val("d1_data", 32'(bus1.m_data), 32'(e[7:0]));
        check_val("d1_last", 32'(bus1.m_last), 32'(e[8]));
      end
    end
  end

  task automatic start_capture(input int which, input logic [47:0] vin, input logic [47:0] vexp);
    logic [8:0] item;
    for (int i = 0; i < SIZE; i++) begin
      item = {((i == SIZE - 1) ? 1'b1 : 1'b0), vexp[8*i +: 8]};
      if (which == 0) q0.push_back(item);
      else q1.push_back(item);
    end
    if (which == 0) begin
      bus0.acc_in  = vin;
      bus0.capture = 1'b1;
    end else begin
      bus1.acc_in  = vin;
      bus1.capture = 1'b1;
    end
    @(posedge clk);
    #1;
    if (which == 0) bus0.capture = 1'b0;
    else bus1.capture = 1'b0;
  endtask

  // Returns at the negedge of the first cycle with m_valid low
  task automatic wait_drain(input int which, input string tag, output int cyc);
    logic v;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      v = (which == 0) ? bus0.m_valid : bus1.m_valid;
      n++;
    end while (v && n < 40);
    cyc = n;
    check_val({tag, "_done"}, 32'(v), 32'd0);
    check_val({tag, "_queue"}, 32'((which == 0) ? q0.size() : q1.size()), 32'd0);
    check_val({tag, "_rdy"}, 32'((which == 0) ? bus0.capture_ready : bus1.capture_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    int clr_before;

    reset        = 1'b0;
    bus0.acc_in  = V1;
    bus0.capture = 1'b1;
    bus0.m_ready = 1'b1;
    bus1.acc_in  = 48'h0;
    bus1.capture = 1'b0;
    bus1.m_ready = 1'b1;

    // reset state, capture held high during reset must be ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_rdy",   32'(bus0.capture_ready), 32'd1);
    check_val("rst_valid", 32'(bus0.m_valid),       32'd0);
    check_val("rst_busy",  32'(bus0.busy),          32'd0);
    check_val("rst_clear", 32'(bus0.acc_clear),     32'd0);
    check_val("rst_data",  32'(bus0.m_data),        32'h00);
    check_val("rst_last",  32'(bus0.m_last),        32'd0);
    reset        = 1'b1;
    bus0.capture = 1'b0;
    @(negedge clk);
    check_val("post_rst_valid", 32'(bus0.m_valid),   32'd0);
    check_val("post_rst_clear", 32'(bus0.acc_clear), 32'd0);
    check_val("post_rst_clrcnt", 32'(clr0), 32'd0);

    // basic drain
    clr_before = clr0;
    start_capture(0, V1, V1);
    @(negedge clk);
    check_val("basic_clear", 32'(bus0.acc_clear),     32'd1);
    check_val("basic_valid", 32'(bus0.m_valid),       32'd1);
    check_val("basic_busy",  32'(bus0.busy),          32'd1);
    check_val("basic_rdy",   32'(bus0.capture_ready), 32'd0);
    check_val("basic_lane0", 32'(bus0.m_data),        32'h01);
    wait_drain(0, "basic", cyc);
    check_val("basic_cycles", 32'(cyc), 32'd6);
    check_val("basic_clrcnt", 32'(clr0 - clr_before), 32'd1);
    check_val("basic_idle_busy", 32'(bus0.busy), 32'd0);

    // backpressure on lane 2
    @(posedge clk);
    #1;
    start_capture(0, V1, V1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus0.m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("bp_data",  32'(bus0.m_data),  32'h03);
      check_val("bp_valid", 32'(bus0.m_valid), 32'd1);
      check_val("bp_last",  32'(bus0.m_last),  32'd0);
      @(posedge clk);
      #1;
    end
    bus0.m_ready = 1'b1;
    @(negedge clk);
    check_val("bp_data_4th", 32'(bus0.m_data), 32'h03);
    wait_drain(0, "bp", cyc);

    // RELU instance
    start_capture(1, VR, VR_EXP);
    @(negedge clk);
    check_val("relu_clear", 32'(bus1.acc_clear), 32'd1);
    wait_drain(1, "relu", cyc);
    check_val("relu_cycles", 32'(cyc), 32'd6);
    check_val("relu_clrcnt", 32'(clr1), 32'd1);

    // ignored capture during SEND, acc_in disturbed, capture on last handshake
    @(posedge clk);
    #1;
    clr_before = clr0;
    start_capture(0, V2, V2);
    bus0.capture = 1'b1;
    bus0.acc_in  = VAA;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    bus0.capture = 1'b0;
    @(negedge clk);
    check_val("ign_valid", 32'(bus0.m_valid),       32'd0);
    check_val("ign_rdy",   32'(bus0.capture_ready), 32'd1);
    check_val("ign_clear", 32'(bus0.acc_clear),     32'd0);
    check_val("ign_queue", 32'(q0.size()),          32'd0);
    @(negedge clk);
    check_val("ign_valid2", 32'(bus0.m_valid), 32'd0);
    check_val("ign_clrcnt", 32'(clr0 - clr_before), 32'd1);

    // reset after lane 2 handshakes
    @(posedge clk);
    #1;
    start_capture(0, V1, V1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    q0.delete();
    clr_before = clr0;
    @(negedge clk);
    check_val("mrst_valid", 32'(bus0.m_valid),       32'd0);
    check_val("mrst_rdy",   32'(bus0.capture_ready), 32'd1);
    check_val("mrst_busy",  32'(bus0.busy),          32'd0);
    check_val("mrst_data",  32'(bus0.m_data),        32'h00);
    repeat (3) begin
      @(negedge clk);
      check_val("mrst_quiet", 32'(bus0.m_valid), 32'd0);
    end
    check_val("mrst_clrcnt", 32'(clr0 - clr_before), 32'd0);
    start_capture(0, V2, V2);
    @(negedge clk);
    check_val("mrst_restart_lane0", 32'(bus0.m_data), 32'h10);
    wait_drain(0, "mrst", cyc);

    // back-to-back: capture in the idle cycle right after m_last
    @(posedge clk);
    #1;
    start_capture(0, V1, V1);
    wait_drain(0, "b2b_a", cyc);
    start_capture(0, V2, V2);
    @(negedge clk);
    check_val("b2b_valid", 32'(bus0.m_valid), 32'd1);
    check_val("b2b_first", 32'(bus0.m_data),  32'h10);
    wait_drain(0, "b2b_b", cyc);
    check_val("b2b_cycles", 32'(cyc), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/acc_drain.md
ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 SHALL have parameter SIZE, default 6: number of 8-bit lanes in the accumulator vector.
REQ-002 SHALL have parameter RELU, default 0: when 1, clamp negative lanes to zero on output.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port acc_in  input  8*SIZE  parallel accumulator vector; lane i = acc_in[8*i +: 8], two's complement.
REQ-006 SHALL have port capture  input  1  request to snapshot acc_in.
REQ-007 SHALL have port capture_ready  output  1  block can accept capture.
REQ-008 SHALL have port acc_clear  output  1  one-cycle pulse telling upstream to clear its accumulators.
REQ-009 SHALL have port m_data  output  8  serialized lane value.
REQ-010 SHALL have port m_valid  output  1  m_data valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts m_data.
REQ-012 SHALL have port m_last  output  1  marks lane SIZE-1.
REQ-013 SHALL have port busy  output  1  high while a vector is being drained.

Function
REQ-014 SHALL implement two states: IDLE and SEND.
REQ-015 IDLE: capture_ready=1, m_valid=0, busy=0.
REQ-016 Capture accepted when capture=1 and capture_ready=1 at a rising edge; at that edge the block SHALL store all SIZE lanes of acc_in, set lane index to 0 and enter SEND.
REQ-017 acc_clear SHALL be 1 for exactly the one cycle after an accepted capture, otherwise 0.
REQ-018 SEND: capture_ready=0, m_valid=1, busy=1; capture SHALL be ignored.
REQ-019 Latency: m_valid SHALL rise in the first cycle after the capture edge, carrying lane 0.
REQ-020 m_data SHALL equal the stored lane[index]; when RELU=1 and bit 7 of the lane is 1, m_data SHALL be 8'h00.
REQ-021 m_last SHALL be 1 only when m_valid=1 and index = SIZE-1.
REQ-022 Handshake occurs when m_valid=1 and m_ready=1 at a rising edge; index SHALL increment by 1, except after lane SIZE-1, where the state SHALL return to IDLE.
REQ-023 While m_valid=1 and m_ready=0, m_data, m_last and index SHALL hold stable; m_valid SHALL NOT drop before the handshake.
REQ-024 Throughput: with m_ready held 1, SIZE lanes SHALL transfer in SIZE consecutive cycles.
REQ-025 capture_ready SHALL return to 1 in the cycle after the last handshake, and a capture in that cycle SHALL be accepted.
REQ-026 A capture asserted in the same cycle as the last handshake SHALL be ignored.
REQ-027 Changes on acc_in after capture SHALL NOT affect the lanes being drained.
REQ-028 The lane index SHALL be ceil(log2(SIZE)) bits wide, minimum 1 bit, and SHALL never exceed SIZE-1.
REQ-029 All outputs SHALL be driven from registers or from the state, stored lanes and index only; no combinational path from m_ready or capture to any output.

Reset
REQ-030 With reset=0 at a rising edge, the block SHALL enter IDLE, clear the index and stored lanes to 0, and drive acc_clear=0, m_valid=0, m_last=0, busy=0, m_data=8'h00 and capture_ready=1 from the next cycle on.
REQ-031 Reset during SEND SHALL abandon the transfer; no remaining lanes SHALL be emitted after reset is released.
REQ-032 capture SHALL be ignored in any cycle where reset=0.

Verification
REQ-033 The bench SHALL cover basic drain: SIZE=6, RELU=0, acc_in lanes 0..5 = 01,02,03,FE,7F,80, capture one cycle, m_ready=1 -> acc_clear pulses once; m_data 01,02,03,FE,7F,80 in 6 consecutive cycles; m_last only on 80; capture_ready=1 on the next cycle.
REQ-034 The bench SHALL cover backpressure: same vector, m_ready=0 for 3 cycles at lane 2 -> m_data holds 03 with m_valid=1 for 4 cycles; the stream completes unaltered.
REQ-035 The bench SHALL cover RELU=1: lanes 05,FB,80,7F,00,FF -> 05,00,00,7F,00,00.
REQ-036 The bench SHALL cover ignored capture and snapshot stability: capture pulsed during SEND and acc_in changed to all AA -> no effect on output; no second acc_clear; a capture in the last-handshake cycle is not accepted.
REQ-037 The bench SHALL cover reset mid-drain: reset=0 for one cycle after lane 2 handshakes -> m_valid=0, capture_ready=1, busy=0 next cycle; no further lanes; a new capture then drains from lane 0.
REQ-038 The bench SHALL cover back-to-back vectors: a capture in the cycle after m_last is accepted -> second vector starts the following cycle, with one idle cycle between the streams.
